ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Initiator for the single-port word RAM interface: accepts one load/store request at a time from the core-side valid/ready channel, drives the RAM strobes, and returns a response.
- The RAM can only write a full word, or the low half or low byte of a word. Sub-word stores to a non-zero byte lane are done as read-modify-write (RMW).
- Sits between the core LSU and the on-chip RAM.

Parameters:
- RAM_SIZE, 1024, RAM depth in 32-bit words. Word index ≥ RAM_SIZE is an error.

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  load data, extended; 0 for stores and errors
- rsp_err_o  out  1  misaligned, out-of-range or illegal size
- ram_en_o  out  1  RAM enable
- ram_we_o  out  4  RAM write strobes: only 0000, 0001, 0011 or 1111 are ever driven
- ram_addr_o  out  32  word-aligned byte address: {addr[31:2],2'b00}
- ram_din_o  out  32  RAM write data
- ram_dout_i  in  32  RAM read data, valid in the same cycle as ram_en_o

Behaviour:
- Reset values: state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; ram_en_o=0; ram_we_o=0; ram_addr_o=0; ram_din_o=0.
- Reset asserted mid-operation: return to IDLE immediately; the pending request and any pending write are dropped, with no response.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- req_ready_o=1 only in IDLE. One outstanding request; no pipelining.
- On accept, register addr, we, size, unsigned and wdata. Decode the request and choose the next state:
  - Error conditions: size=11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ RAM_SIZE.
  - Error → RESP with err=1, rdata=0. No RAM cycle.
  - Load, or direct store → ACCESS. Direct stores are: word; half at offset 0; byte at offset 0.
  - Any other sub-word store → RMW_RD.
- ACCESS, one cycle:
  - ram_en_o=1.
  - Store strobes: word → we=1111, din=wdata; half → we=0011, din={16'b0,wdata[15:0]}; byte → we=0001, din={24'b0,wdata[7:0]}.
  - Load: we=0000. Capture ram_dout_i at the clock edge, then:
    - Shift right by 8*addr[1:0].
    - Take [7:0] for byte or [15:0] for half, whole word for word.
    - Sign- or zero-extend per unsigned.
    - Register the result into rsp_rdata_o.
  - → RESP.
- RMW_RD, one cycle: en=1, we=0000. Capture ram_dout_i into the merge register. → RMW_WR.
- RMW_WR, one cycle: en=1, we=1111, din=captured word with the byte lane at addr[1:0] (or half at 2) replaced by wdata. → RESP.
- RESP: rsp_valid_o=1; data and err held stable until rsp_ready_i. On handshake → IDLE. The next request can be accepted the following cycle.
- Outside ACCESS, RMW_RD and RMW_WR: ram_en_o=0 and ram_we_o=0. ram_addr_o holds the registered aligned address in all states.
- Latency from accept edge to first rsp_valid cycle: error 1 cycle; load or direct store 2; RMW 3.
- Back-to-back: rsp_ready_i held high gives one request per 3 cycles (load).
- rsp_ready_i high outside RESP has no effect.
- req_* inputs are ignored when not in IDLE.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load 0x10 → RAM word 4 = 0xDEADBEEF; load rsp_rdata 0xDEADBEEF, err 0; we=1111 seen once; load rsp_valid 2 cycles after accept.
- RAM word 4=0x11223344; byte store 0xAA to 0x12 → RMW_RD then RMW_WR (we=1111, din 0x11AA3344); word 4=0x11AA3344; rsp_valid 3 cycles after accept.
- Byte store 0x55 to 0x14 and half store 0xBEEF to 0x18 → single ACCESS cycles with we=0001 and we=0011; no RMW read.
- Word 4=0x8081F0F0: signed byte load 0x13 → 0xFFFFFF80; unsigned half load 0x12 → 0x00008081; signed half load 0x10 → 0xFFFFF0F0.
- Half load 0x11, word store 0x22, size=11, word load 0x1000 (RAM_SIZE=1024) → each err=1, rdata 0, ram_en_o never asserted, rsp_valid 1 cycle after accept.
- rsp_ready_i low 5 cycles in RESP → rsp_valid/rdata stable, req_ready_o=0. rstn_i pulsed during RMW_RD → outputs at reset values, no write, no response.

Source files
------------

// File: rtl/ram_master.sv
// ram_master: single-request load/store initiator for a word RAM, with read-modify-write for unaligned sub-word stores
//   clk, rstn_i      : clock, asynchronous active-low reset
//   req_*            : core-side request channel (valid/ready), byte address, size, signedness, store data
//   rsp_*            : response channel (valid/ready), extended load data, error flag
//   ram_*            : RAM strobes; ram_dout_i is valid in the same cycle as ram_en_o
module ram_master #(
  parameter int RAM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_din_o,
  input  logic [31:0] ram_dout_i
);
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
  state_t state, next;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, err_q;
  logic        req_err, req_direct;
  logic [4:0]  sh;
  logic [31:0] rd_sh, load_val, lane_mask, merged, size_mask;
  assign req_err = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
                   (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) || req_addr_i[31:2] >= 30'(RAM_SIZE);
  assign req_direct = req_size_i == 2'b10 || req_addr_i[1:0] == 2'b00;
  // The RAM only writes low lanes, so a sub-word store elsewhere becomes a full-word write of a merged word
  always_comb begin
    sh        = {addr_q[1:0], 3'b000};
    rd_sh     = ram_dout_i >> sh;
    load_val  = size_q == 2'b00 ? {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]} :
                size_q == 2'b01 ? {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
    size_mask = size_q == 2'b10 ? 32'hFFFF_FFFF : size_q == 2'b01 ? 32'h0000_FFFF : 32'h0000_00FF;
    lane_mask = size_mask << sh;
    merged    = (merge_q & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  end
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= next;
  always_comb begin
    next        = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_din_o   = 32'h0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) next = req_err ? RESP : (!req_we_i || req_direct) ? ACCESS : RMW_RD;
      end
      ACCESS: begin
        ram_en_o  = 1'b1;
        ram_we_o  = !we_q ? 4'b0000 : size_q == 2'b10 ? 4'b1111 : size_q == 2'b01 ? 4'b0011 : 4'b0001;
        ram_din_o = we_q ? wdata_q & size_mask : 32'h0;
        next      = RESP;
      end
      RMW_RD: begin
        ram_en_o = 1'b1;
        next     = RMW_WR;
      end
      RMW_WR: begin
        ram_en_o  = 1'b1;
        ram_we_o  = 4'b1111;
        ram_din_o = merged;
        next      = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state == ACCESS && !we_q) rdata_q <= load_val;
      if (state == RMW_RD) merge_q <= ram_dout_i;
    end
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign ram_addr_o  = {addr_q[31:2], 2'b00};
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: table-driven check of ram_master against a behavioural RAM, plus stall and mid-RMW reset sequences
module tb_ram_master;
  logic        clk = 0, rstn = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_uns = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;
  bit   [31:0] mem [1024];
  int          en_cnt = 0, wr_cnt = 0;
  logic [3:0]  last_we = 0;
  logic [31:0] last_din = 0;
  int          checks = 0, errors = 0;

  ram_master #(.RAM_SIZE(1024)) dut (
    .clk(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;
  assign ram_dout = mem[ram_addr[11:2]];
  always @(posedge clk)
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_we != 4'b0000) begin
        wr_cnt   <= wr_cnt + 1;
        last_we  <= ram_we;
        last_din <= ram_din;
        for (int i = 0; i < 4; i++) if (ram_we[i]) mem[ram_addr[11:2]][8*i +: 8] <= ram_din[8*i +: 8];
      end
    end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          lat, en;
    logic [3:0]  lwe;
    logic [31:0] ldin;
  } vec_t;
  vec_t v [27];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic err, int lat, int en, logic [3:0] lwe, logic [31:0] ldin);
    mk = '{we, size, uns, addr, wdata, rdata, err, lat, en, lwe, ldin};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(string n);
    check({n, "_req_ready"}, 32'(req_ready), 1);
    check({n, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({n, "_rsp_rdata"}, rsp_rdata, 0);
    check({n, "_rsp_err"}, 32'(rsp_err), 0);
    check({n, "_ram_en"}, 32'(ram_en), 0);
    check({n, "_ram_we"}, 32'(ram_we), 0);
    check({n, "_ram_addr"}, ram_addr, 0);
    check({n, "_ram_din"}, ram_din, 0);
  endtask

  task automatic issue(input vec_t t, output logic [31:0] rd, output logic e, output int lat, output int en_d);
    int en0;
    @(negedge clk);
    req_valid = 1; req_we = t.we; req_size = t.size; req_uns = t.uns; req_addr = t.addr; req_wdata = t.wdata;
    rsp_ready = 1;
    en0 = en_cnt;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = rsp_rdata;
    e = rsp_err;
    en_d = en_cnt - en0;
    @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, hold;
    logic        e;
    int          lat, en_d, wr0;
    v[0]  = mk(1, 2, 0, 32'h10,   32'hDEADBEEF, 32'h0, 0, 2, 1, 4'hF, 32'hDEADBEEF);
    v[1]  = mk(0, 2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0);
    v[2]  = mk(1, 2, 0, 32'h10,   32'h11223344, 32'h0, 0, 2, 1, 4'hF, 32'h11223344);
    v[3]  = mk(1, 0, 0, 32'h12,   32'h123456AA, 32'h0, 0, 3, 2, 4'hF, 32'h11AA3344);
    v[4]  = mk(0, 2, 0, 32'h10,   32'h0,        32'h11AA3344, 0, 2, 1, 0, 0);
    v[5]  = mk(1, 0, 0, 32'h14,   32'hFFFFFF55, 32'h0, 0, 2, 1, 4'h1, 32'h00000055);
    v[6]  = mk(1, 1, 0, 32'h18,   32'h1234BEEF, 32'h0, 0, 2, 1, 4'h3, 32'h0000BEEF);
    v[7]  = mk(0, 2, 0, 32'h14,   32'h0,        32'h00000055, 0, 2, 1, 0, 0);
    v[8]  = mk(0, 2, 0, 32'h18,   32'h0,        32'h0000BEEF, 0, 2, 1, 0, 0);
    v[9]  = mk(1, 2, 0, 32'h10,   32'h8081F0F0, 32'h0, 0, 2, 1, 4'hF, 32'h8081F0F0);
    v[10] = mk(0, 0, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 0);
    v[11] = mk(0, 1, 1, 32'h12,   32'h0,        32'h00008081, 0, 2, 1, 0, 0);
    v[12] = mk(0, 1, 0, 32'h10,   32'h0,        32'hFFFFF0F0, 0, 2, 1, 0, 0);
    v[13] = mk(0, 0, 1, 32'h11,   32'h0,        32'h000000F0, 0, 2, 1, 0, 0);
    v[14] = mk(0, 0, 0, 32'h12,   32'h0,        32'hFFFFFF81, 0, 2, 1, 0, 0);
    v[15] = mk(1, 1, 0, 32'h12,   32'h00001234, 32'h0, 0, 3, 2, 4'hF, 32'h1234F0F0);
    v[16] = mk(0, 2, 1, 32'h10,   32'h0,        32'h1234F0F0, 0, 2, 1, 0, 0);
    v[17] = mk(1, 0, 0, 32'h13,   32'h0000009C, 32'h0, 0, 3, 2, 4'hF, 32'h9C34F0F0);
    v[18] = mk(0, 2, 0, 32'h10,   32'h0,        32'h9C34F0F0, 0, 2, 1, 0, 0);
    v[19] = mk(0, 1, 0, 32'h11,   32'h0,        32'h0, 1, 1, 0, 0, 0);
    v[20] = mk(1, 2, 0, 32'h22,   32'h12345678, 32'h0, 1, 1, 0, 0, 0);
    v[21] = mk(0, 3, 0, 32'h10,   32'h0,        32'h0, 1, 1, 0, 0, 0);
    v[22] = mk(0, 2, 0, 32'h1000, 32'h0,        32'h0, 1, 1, 0, 0, 0);
    v[23] = mk(1, 0, 0, 32'h1001, 32'h000000EE, 32'h0, 1, 1, 0, 0, 0);
    v[24] = mk(0, 2, 0, 32'hFFC,  32'h0,        32'h0, 0, 2, 1, 0, 0);
    v[25] = mk(1, 2, 0, 32'hFFC,  32'hCAFEF00D, 32'h0, 0, 2, 1, 4'hF, 32'hCAFEF00D);
    v[26] = mk(0, 0, 1, 32'hFFF,  32'h0,        32'h000000CA, 0, 2, 1, 0, 0);

    repeat (2) @(negedge clk);
    chk_reset("rst");
    rstn = 1;
    for (int i = 0; i < 27; i++) begin
      issue(v[i], rd, e, lat, en_d);
      check($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      check($sformatf("v%0d_err", i), 32'(e), 32'(v[i].err));
      check($sformatf("v%0d_lat", i), lat, v[i].lat);
      check($sformatf("v%0d_en", i), en_d, v[i].en);
      if (v[i].we && !v[i].err) begin
        check($sformatf("v%0d_we", i), 32'(last_we), 32'(v[i].lwe));
        check($sformatf("v%0d_din", i), last_din, v[i].ldin);
      end
    end
    check("mem4", mem[4], 32'h9C34F0F0);
    check("mem5", mem[5], 32'h00000055);
    check("mem6", mem[6], 32'h0000BEEF);

    // response stall: data held and no new request accepted while rsp_ready is low
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2; req_uns = 0; req_addr = 32'h10; rsp_ready = 0;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 check("stall_first_valid", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", i), 32'(rsp_valid), 1);
      check($sformatf("stall%0d_rdata", i), rsp_rdata, 32'h9C34F0F0);
      check($sformatf("stall%0d_ready", i), 32'(req_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    check("stall_done_valid", 32'(rsp_valid), 0);
    check("stall_done_ready", 32'(req_ready), 1);

    // asynchronous reset while in RMW_RD drops the store with no response
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 0; req_addr = 32'h11; req_wdata = 32'h77;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 0;
    check("rmw_rd_en", 32'(ram_en), 1);
    check("rmw_rd_we", 32'(ram_we), 0);
    rstn = 0;
    #1 chk_reset("midrst");
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("midrst_norsp%0d", i), 32'(rsp_valid), 0);
    end
    check("midrst_nowrite", wr_cnt - wr0, 0);
    issue(mk(0, 2, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0), rd, e, lat, en_d);
    hold = rd;
    check("midrst_mem4", hold, 32'h9C34F0F0);
    check("midrst_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
